debug_tx_scheduler: RTL and testbench

//  Shares the debugger UART transmitter between two requesters: run-to-end (fast) and

---
 rtl/debug_tx_scheduler_if.sv | 43 ++++
 rtl/debug_tx_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_debug_tx_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_tx_scheduler_if.sv
// Bundle of request, snapshot and UART-handshake signals between the debugger FSMs,
// the transmit scheduler (slave side) and the UART TX.
interface debug_tx_scheduler_if #(
    parameter int DATA_W = 2560,
    parameter int CNT_W  = 32
);
    logic              is_req_fast;
    logic              is_req_step;
    logic [DATA_W-1:0] i_data_from_mips;
    logic [CNT_W-1:0]  i_clk_count;
    logic              is_tx_done;
    logic [7:0]        o_tx_data;
    logic              os_tx_start;
    logic              os_done_fast;
    logic              os_done_step;
    logic              o_busy;

    modport slave (
        input  is_req_fast,
        input  is_req_step,
        input  i_data_from_mips,
        input  i_clk_count,
        input  is_tx_done,
        output o_tx_data,
        output os_tx_start,
        output os_done_fast,
        output os_done_step,
        output o_busy
    );

    modport master (
        output is_req_fast,
        output is_req_step,
        output i_data_from_mips,
        output i_clk_count,
        output is_tx_done,
        input  o_tx_data,
        input  os_tx_start,
        input  os_done_fast,
        input  os_done_step,
        input  o_busy
    );
endinterface

// File: rtl/debug_tx_scheduler.sv
// Round-robin arbiter streaming a count+snapshot frame byte-by-byte to the UART TX.
// Optional XOR checksum trailer byte when DBG_TX_CHECKSUM_EN is defined.
module debug_tx_scheduler #(
    parameter int DATA_W = 2560,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    debug_tx_scheduler_if.slave  bus
);
    localparam int FRAME_W = DATA_W + CNT_W;
    localparam int NBYTES  = FRAME_W / 8;
`ifdef DBG_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(NBYTES);
`else
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(NBYTES - 1);
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic GRANT_FAST = 1'b0;
    localparam logic GRANT_STEP = 1'b1;

    logic [2:0]         state_q, state_d;
    logic               pend_fast_q, pend_fast_d;
    logic               pend_step_q, pend_step_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_nxt_s;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               done_fast_q, done_fast_d;
    logic               done_step_q, done_step_d;
    logic               busy_q, busy_d;
    logic               fast_active_s, step_active_s;
`ifdef DBG_TX_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;

    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction
`endif

    // Shadow byte k of the frame; count occupies the low bytes so it goes out first.
    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame,
                                              input logic [IDX_W-1:0]   idx);
        return frame[{idx, 3'b000} +: 8];
    endfunction

    assign bus.o_tx_data    = tx_data_q;
    assign bus.os_tx_start  = tx_start_q;
    assign bus.os_done_fast = done_fast_q;
    assign bus.os_done_step = done_step_q;
    assign bus.o_busy       = busy_q;

    // Next-state logic: request capture, arbitration and byte sequencing.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        done_fast_d  = 1'b0;
        done_step_d  = 1'b0;
        idx_nxt_s    = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
`ifdef DBG_TX_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        // A requester whose own frame is in flight cannot queue another one.
        fast_active_s = (state_q != S_IDLE) && (grant_q == GRANT_FAST);
        step_active_s = (state_q != S_IDLE) && (grant_q == GRANT_STEP);
        pend_fast_d   = pend_fast_q | (bus.is_req_fast & ~fast_active_s);
        pend_step_d   = pend_step_q | (bus.is_req_step & ~step_active_s);

        case (state_q)
            S_IDLE: begin
                if (pend_fast_q && (!pend_step_q || (last_grant_q == GRANT_STEP))) begin
                    grant_d     = GRANT_FAST;
                    pend_fast_d = 1'b0;
                    state_d     = S_LATCH;
                end else if (pend_step_q) begin
                    grant_d     = GRANT_STEP;
                    pend_step_d = 1'b0;
                    state_d     = S_LATCH;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_LATCH: begin
                shadow_d   = {bus.i_data_from_mips, bus.i_clk_count};
                idx_d      = {IDX_W{1'b0}};
                tx_data_d  = bus.i_clk_count[7:0];
                tx_start_d = 1'b1;
`ifdef DBG_TX_CHECKSUM_EN
                csum_d     = csum_update(8'h00, bus.i_clk_count[7:0]);
`endif
                state_d    = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.is_tx_done) begin
                    if (idx_q == LAST) begin
                        done_fast_d = (grant_q == GRANT_FAST);
                        done_step_d = (grant_q == GRANT_STEP);
                        state_d     = S_DONE;
                    end else begin
                        idx_d      = idx_nxt_s;
                        tx_start_d = 1'b1;
`ifdef DBG_TX_CHECKSUM_EN
                        if (idx_nxt_s > LAST_DATA) begin
                            tx_data_d = csum_q;
                        end else begin
                            tx_data_d = frame_byte(shadow_q, idx_nxt_s);
                            csum_d    = csum_update(csum_q, frame_byte(shadow_q, idx_nxt_s));
                        end
`else
                        tx_data_d  = frame_byte(shadow_q, idx_nxt_s);
`endif
                        state_d    = S_START;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_fast_q  <= 1'b0;
            pend_step_q  <= 1'b0;
            grant_q      <= GRANT_STEP;
            last_grant_q <= GRANT_STEP;
            idx_q        <= {IDX_W{1'b0}};
            shadow_q     <= {FRAME_W{1'b0}};
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            done_fast_q  <= 1'b0;
            done_step_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef DBG_TX_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            pend_fast_q  <= pend_fast_d;
            pend_step_q  <= pend_step_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            done_fast_q  <= done_fast_d;
            done_step_q  <= done_step_d;
            busy_q       <= busy_d;
`ifdef DBG_TX_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_debug_tx_scheduler.sv
// Directed bench for debug_tx_scheduler: table-checked frame bytes plus hand-written
// arbitration, coalescing, mid-frame data change, reset and checksum sequences.
module tb_debug_tx_scheduler;
    localparam int DATA_W = 2560;
    localparam int CNT_W  = 32;
`ifdef DBG_TX_CHECKSUM_EN
    localparam int FRAME_LEN = 325;
`else
    localparam int FRAME_LEN = 324;
`endif

    typedef struct packed {
        logic [15:0] idx;
        logic [7:0]  exp_byte;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_tx_scheduler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

    debug_tx_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W), .IDX_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx_q[$];
    int         order_q[$];
    int         gap_q[$];
    int         n_start = 0;
    int         n_done_fast = 0;
    int         n_done_step = 0;
    int         cyc = 0;
    int         last_done_cyc = 0;
    bit         gap_armed = 1'b0;
    vec_t       vecs[8];

    // Output monitor: records every transmitted byte, done pulse and done-to-start gap.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.os_tx_start) begin
                rx_q.push_back(bus.o_tx_data);
                n_start++;
                if (gap_armed) begin
                    gap_q.push_back(cyc - last_done_cyc);
                    gap_armed = 1'b0;
                end
            end
            if (bus.os_done_fast) begin
                n_done_fast++;
                order_q.push_back(0);
                last_done_cyc = cyc;
                gap_armed = 1'b1;
            end
            if (bus.os_done_step) begin
                n_done_step++;
                order_q.push_back(1);
                last_done_cyc = cyc;
                gap_armed = 1'b1;
            end
        end
    end

    // UART model: acknowledges each started byte a few cycles later with a 1-cycle done.
    initial begin
        int cd;
        cd = -1;
        bus.is_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.is_tx_done = 1'b0;
            if (cd == 0) begin
                bus.is_tx_done = 1'b1;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (bus.os_tx_start) cd = 2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        rx_q.delete();
        order_q.delete();
        gap_q.delete();
        n_start = 0;
        n_done_fast = 0;
        n_done_step = 0;
        gap_armed = 1'b0;
    endtask

    task automatic pulse(input bit f, input bit s);
        bus.is_req_fast = f;
        bus.is_req_step = s;
        @(negedge clk);
        bus.is_req_fast = 1'b0;
        bus.is_req_step = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int i;
        i = 0;
        while ((n_done_fast + n_done_step) < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        check(name, n_done_fast + n_done_step, target);
    endtask

    task automatic wait_bytes(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (rx_q.size() < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, (rx_q.size() >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic set_pattern();
        for (int k = 0; k < DATA_W / 8; k++) bus.i_data_from_mips[8*k +: 8] = 8'(k);
    endtask

    function automatic logic [7:0] model_byte(input int i, input logic [31:0] cnt, input bit zero_data);
        logic [7:0] x;
        x = 8'h00;
        if (i < 4) begin
            x = cnt[8*i +: 8];
        end else if (i < 324) begin
            x = zero_data ? 8'h00 : 8'(i - 4);
        end else begin
            for (int j = 0; j < 4; j++) x = x ^ cnt[8*j +: 8];
            for (int j = 0; j < 320; j++) x = x ^ (zero_data ? 8'h00 : 8'(j));
        end
        return x;
    endfunction

    task automatic check_frame(input string name, input logic [31:0] cnt, input bit zero_data);
        int nbad;
        nbad = 0;
        check({name, "_len"}, rx_q.size(), FRAME_LEN);
        for (int i = 0; i < rx_q.size() && i < FRAME_LEN; i++) begin
            if (rx_q[i] !== model_byte(i, cnt, zero_data)) nbad++;
        end
        check({name, "_bad_bytes"}, nbad, 0);
    endtask

    initial begin
        int start_at_rst;
        logic [7:0] got;
        logic [3:0] order_bits;

        vecs[0] = '{idx: 16'd0,   exp_byte: 8'h10};
        vecs[1] = '{idx: 16'd1,   exp_byte: 8'h00};
        vecs[2] = '{idx: 16'd4,   exp_byte: 8'h00};
        vecs[3] = '{idx: 16'd5,   exp_byte: 8'h01};
        vecs[4] = '{idx: 16'd67,  exp_byte: 8'h3F};
        vecs[5] = '{idx: 16'd259, exp_byte: 8'hFF};
        vecs[6] = '{idx: 16'd260, exp_byte: 8'h00};
        vecs[7] = '{idx: 16'd323, exp_byte: 8'h3F};

        rst = 1'b1;
        bus.is_req_fast = 1'b0;
        bus.is_req_step = 1'b0;
        bus.i_data_from_mips = '0;
        bus.i_clk_count = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", bus.os_tx_start, 1'b0);
        check("rst_tx_data", bus.o_tx_data, 8'h00);
        check("rst_done_fast", bus.os_done_fast, 1'b0);
        check("rst_done_step", bus.os_done_step, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: single fast frame, latency and byte table.
        bus.i_clk_count = 32'h0000_0010;
        set_pattern();
        clear_stats();
        pulse(1'b1, 1'b0);
        check("t1_busy_grant", bus.o_busy, 1'b0);
        @(negedge clk);
        check("t1_start_early", bus.os_tx_start, 1'b0);
        check("t1_busy_latch", bus.o_busy, 1'b1);
        @(negedge clk);
        check("t1_start_latency", bus.os_tx_start, 1'b1);
        check("t1_first_byte", bus.o_tx_data, 8'h10);
        wait_done(1, 4000, "t1_done");
        for (int v = 0; v < 8; v++) begin
            got = (rx_q.size() > int'(vecs[v].idx)) ? rx_q[vecs[v].idx] : 8'hxx;
            check($sformatf("t1_byte%0d", vecs[v].idx), got, vecs[v].exp_byte);
        end
        check_frame("t1_frame", 32'h0000_0010, 1'b0);
        check("t1_starts", n_start, FRAME_LEN);
        check("t1_done_fast", n_done_fast, 1);
        check("t1_done_step", n_done_step, 0);
        check("t1_busy_end", bus.o_busy, 1'b0);

        // Test 2: simultaneous requests, round-robin from reset.
        do_reset();
        clear_stats();
        pulse(1'b1, 1'b1);
        wait_done(2, 8000, "t2_pair1");
        repeat (5) @(negedge clk);
        pulse(1'b1, 1'b1);
        wait_done(4, 8000, "t2_pair2");
        order_bits = 4'hF;
        for (int i = 0; i < order_q.size() && i < 4; i++) order_bits[i] = order_q[i][0];
        check("t2_n_frames", order_q.size(), 4);
        check("t2_order", order_bits, 4'b1010);
        check("t2_starts", n_start, 4 * FRAME_LEN);
        check("t2_gap1", (gap_q.size() > 0) ? gap_q[0] : -1, 3);
        check("t2_gap3", (gap_q.size() > 2) ? gap_q[2] : -1, 3);

        // Test 3: repeated step pulses during its own frame coalesce.
        clear_stats();
        pulse(1'b0, 1'b1);
        for (int r = 0; r < 5; r++) begin
            repeat (40) @(negedge clk);
            pulse(1'b0, 1'b1);
        end
        wait_done(1, 4000, "t3_done");
        repeat (20) @(negedge clk);
        check("t3_done_step", n_done_step, 1);
        check("t3_done_fast", n_done_fast, 0);
        check("t3_starts", n_start, FRAME_LEN);
        check("t3_busy", bus.o_busy, 1'b0);

        // Test 4: snapshot changes mid-frame do not leak into the frame.
        clear_stats();
        pulse(1'b1, 1'b0);
        wait_bytes(11, 500, "t4_reach_byte10");
        bus.i_data_from_mips = '1;
        wait_done(1, 4000, "t4_done");
        check_frame("t4_frame", 32'h0000_0010, 1'b0);
        set_pattern();

        // Test 5: reset mid-frame drops the frame and the pending request.
        clear_stats();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_bytes(101, 1000, "t5_reach_byte100");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_tx_start", bus.os_tx_start, 1'b0);
        check("t5_tx_data", bus.o_tx_data, 8'h00);
        check("t5_done_fast", bus.os_done_fast, 1'b0);
        check("t5_done_step", bus.os_done_step, 1'b0);
        check("t5_busy", bus.o_busy, 1'b0);
        start_at_rst = n_start;
        repeat (30) @(negedge clk);
        check("t5_no_restart", n_start, start_at_rst);
        check("t5_no_done", n_done_fast + n_done_step, 0);
        clear_stats();
        pulse(1'b1, 1'b0);
        wait_done(1, 4000, "t5_new_done");
        check_frame("t5_frame", 32'h0000_0010, 1'b0);

`ifdef DBG_TX_CHECKSUM_EN
        // Test 6: checksum trailer.
        clear_stats();
        bus.i_clk_count = 32'h0102_0304;
        bus.i_data_from_mips = '0;
        pulse(1'b1, 1'b0);
        wait_done(1, 4000, "t6_done");
        check("t6_trailer", (rx_q.size() == 325) ? rx_q[324] : 8'hxx, 8'h04);
        check_frame("t6_frame", 32'h0102_0304, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
